// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO.
package fifo_pkg;

  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;

  // Occupancy and pointers need one extra bit to tell full from empty.
  function automatic int level_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one synchronous write port, one synchronous read port.
module fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Write port; array contents are never reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register; only the output register is cleared so r_data reads 0 after reset.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO: pointer/level/flag control around a fifo_ram instance.
module fifo_sync_param import fifo_pkg::*; #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 8,
  parameter int AFULL_THRESH  = (2**ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = FWFT_OFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  w_push,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_full,
  output logic                  w_almost_full,
  output logic                  w_overflow,
  input  logic                  r_pop,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_empty,
  output logic                  r_almost_empty,
  output logic                  r_underflow,
  output logic [ADDR_WIDTH:0]   level
);

  localparam int            LW     = level_width(ADDR_WIDTH);
  localparam logic [LW-1:0] ONE    = LW'(1);
  localparam logic [LW-1:0] AF_LVL = LW'(AFULL_THRESH);
  localparam logic [LW-1:0] AE_LVL = LW'(AEMPTY_THRESH);

  logic [LW-1:0]         wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, level_nxt;
  logic                  push_acc, pop_acc, empty_nxt, full_nxt;
  logic                  ram_re, byp;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic [DATA_WIDTH-1:0] ram_q, byp_data;

  // Flush swallows both requests; a full FIFO rejects push, an empty one rejects pop.
  assign push_acc = w_push & ~w_full  & ~flush;
  assign pop_acc  = r_pop  & ~r_empty & ~flush;

  // Next pointers, level and the flags derived from them.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    level_nxt  = level;
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      level_nxt  = '0;
    end else begin
      if (push_acc) wr_ptr_nxt = wr_ptr + ONE;
      if (pop_acc)  rd_ptr_nxt = rd_ptr + ONE;
      case ({push_acc, pop_acc})
        2'b10:   level_nxt = level + ONE;
        2'b01:   level_nxt = level - ONE;
        default: level_nxt = level;
      endcase
    end
    empty_nxt = (wr_ptr_nxt == rd_ptr_nxt);
    full_nxt  = (wr_ptr_nxt[ADDR_WIDTH-1:0] == rd_ptr_nxt[ADDR_WIDTH-1:0]) &&
                (wr_ptr_nxt[ADDR_WIDTH] != rd_ptr_nxt[ADDR_WIDTH]);
  end

  // Control state and registered flags; overflow/underflow only clear on rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level          <= '0;
      w_full         <= 1'b0;
      w_almost_full  <= 1'b0;
      w_overflow     <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_underflow    <= 1'b0;
    end else begin
      wr_ptr         <= wr_ptr_nxt;
      rd_ptr         <= rd_ptr_nxt;
      level          <= level_nxt;
      w_full         <= full_nxt;
      w_almost_full  <= (level_nxt >= AF_LVL);
      r_empty        <= empty_nxt;
      r_almost_empty <= (level_nxt <= AE_LVL);
      w_overflow     <= w_overflow  | (w_push & w_full  & ~flush);
      r_underflow    <= r_underflow | (r_pop  & r_empty & ~flush);
    end
  end

  // Registered-read mode reads on pop only, so r_data holds between pops.
  // FWFT mode prefetches the next head every cycle the FIFO will be non-empty.
  assign ram_re    = (FWFT == FWFT_ON) ? (level_nxt != '0) : pop_acc;
  assign ram_raddr = (FWFT == FWFT_ON) ? rd_ptr_nxt[ADDR_WIDTH-1:0]
                                       : rd_ptr[ADDR_WIDTH-1:0];

  // A word written into the slot that becomes head this edge is not yet in
  // the RAM read path, so it is forwarded straight from w_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      byp      <= 1'b0;
      byp_data <= '0;
    end else if ((FWFT == FWFT_ON) && ram_re) begin
      byp      <= push_acc && (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr_nxt[ADDR_WIDTH-1:0]);
      byp_data <= w_data;
    end
  end

  assign r_data = byp ? byp_data : ram_q;

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (push_acc),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata (w_data),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench: both read modes driven in lockstep, checked against a queue model.
module tb_fifo_sync_param;

  localparam int DW = 8, AW = 3, DEPTH = 8, AF = 6, AE = 2;

  logic          clk = 1'b0, rst = 1'b1, flush = 1'b0, w_push = 1'b0, r_pop = 1'b0;
  logic [DW-1:0] w_data = '0;

  logic          full0, af0, ovf0, emp0, ae0, unf0;
  logic          full1, af1, ovf1, emp1, ae1, unf1;
  logic [DW-1:0] rd0, rd1;
  logic [AW:0]   lvl0, lvl1;

  fifo_sync_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(AF),
                    .AEMPTY_THRESH(AE), .FWFT(0)) u_reg (
    .clk(clk), .rst(rst), .flush(flush), .w_push(w_push), .w_data(w_data),
    .w_full(full0), .w_almost_full(af0), .w_overflow(ovf0), .r_pop(r_pop),
    .r_data(rd0), .r_empty(emp0), .r_almost_empty(ae0), .r_underflow(unf0),
    .level(lvl0));

  fifo_sync_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(AF),
                    .AEMPTY_THRESH(AE), .FWFT(1)) u_ft (
    .clk(clk), .rst(rst), .flush(flush), .w_push(w_push), .w_data(w_data),
    .w_full(full1), .w_almost_full(af1), .w_overflow(ovf1), .r_pop(r_pop),
    .r_data(rd1), .r_empty(emp1), .r_almost_empty(ae1), .r_underflow(unf1),
    .level(lvl1));

  always #5 clk = ~clk;

  int   vecs = 0, errs = 0;
  bit   chk_en = 1'b0;

  // Reference state: stored words in order, sticky flags, last popped word.
  logic [DW-1:0] q[$];
  bit            m_ovf = 1'b0, m_unf = 1'b0;
  logic [DW-1:0] m_rd = '0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model update at each edge from the inputs applied during the previous cycle.
  always @(posedge clk) begin
    int n;
    n = q.size();
    if (rst) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_rd  = '0;
    end else if (flush) begin
      q.delete();
    end else begin
      if (w_push && n == DEPTH) m_ovf = 1'b1;
      if (r_pop && n == 0)      m_unf = 1'b1;
      if (r_pop && n > 0)       m_rd = q.pop_front();
      if (w_push && n < DEPTH)  q.push_back(w_data);
    end
  end

  // Compare every cycle, half a period after the edge.
  always @(negedge clk) begin
    int n;
    n = q.size();
    if (chk_en) begin
      chk("level",       32'(lvl0), 32'(n));
      chk("level_ft",    32'(lvl1), 32'(n));
      chk("empty",       32'(emp0), 32'(n == 0));
      chk("empty_ft",    32'(emp1), 32'(n == 0));
      chk("full",        32'(full0), 32'(n == DEPTH));
      chk("full_ft",     32'(full1), 32'(n == DEPTH));
      chk("afull",       32'(af0),  32'(n >= AF));
      chk("afull_ft",    32'(af1),  32'(n >= AF));
      chk("aempty",      32'(ae0),  32'(n <= AE));
      chk("aempty_ft",   32'(ae1),  32'(n <= AE));
      chk("overflow",    32'(ovf0), 32'(m_ovf));
      chk("overflow_ft", 32'(ovf1), 32'(m_ovf));
      chk("underflow",   32'(unf0), 32'(m_unf));
      chk("underflow_ft",32'(unf1), 32'(m_unf));
      chk("rdata_reg",   32'(rd0),  32'(m_rd));
      if (n > 0) chk("rdata_fwft_head", 32'(rd1), 32'(q[0]));
    end
  end

  // Apply one cycle of inputs at a falling edge; returns at the next falling edge.
  task automatic step(input bit p, input logic [DW-1:0] d, input bit po,
                      input bit f = 1'b0, input bit r = 1'b0);
    w_push = p; w_data = d; r_pop = po; flush = f; rst = r;
    @(negedge clk);
  endtask

  initial begin
    int pp, pq;
    @(negedge clk);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk_en = 1'b1;

    // Reset values.
    chk("rst_level",  32'(lvl0), 0);
    chk("rst_empty",  32'(emp0), 1);
    chk("rst_aempty", 32'(ae0),  1);
    chk("rst_full",   32'(full0), 0);
    chk("rst_afull",  32'(af0),  0);
    chk("rst_ovf",    32'(ovf0), 0);
    chk("rst_unf",    32'(unf0), 0);
    chk("rst_rd",     32'(rd0),  0);
    chk("rst_rd_ft",  32'(rd1),  0);

    // Fill 1..8, then one rejected push.
    for (int i = 1; i <= 8; i++) begin
      step(1, 8'(i), 0);
      chk("fill_afull", 32'(af0), 32'(i >= 6));
    end
    chk("fill_full",  32'(full0), 1);
    chk("fill_level", 32'(lvl0), 8);
    step(1, 8'd9, 0);
    chk("ovf_set",    32'(ovf0), 1);
    chk("ovf_level",  32'(lvl0), 8);
    chk("ft_head1",   32'(rd1),  1);

    // Drain in order, then one rejected pop.
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 1);
      chk("drain_data", 32'(rd0), 32'(i));
    end
    chk("drain_empty", 32'(emp0), 1);
    step(0, 0, 1);
    chk("unf_set",     32'(unf0), 1);

    // FWFT: word is visible the cycle empty falls, no pop.
    step(1, 8'hA5, 0);
    chk("ft_empty_fall", 32'(emp1), 0);
    chk("ft_a5",         32'(rd1),  32'h0A5);

    // Bring to level 4, then 20 cycles of push+pop.
    for (int i = 0; i < 3; i++) step(1, 8'(16 + i), 0);
    chk("lvl4", 32'(lvl0), 4);
    for (int k = 0; k < 20; k++) begin
      step(1, 8'(32 + k), 1);
      chk("steady_level", 32'(lvl0), 4);
      chk("steady_data",  32'(rd0),
          (k == 0) ? 32'h0A5 : (k < 4) ? 32'(15 + k) : 32'(32 + k - 4));
    end

    // Level 5, then flush with requests present.
    step(1, 8'h50, 0);
    chk("lvl5", 32'(lvl0), 5);
    step(1, 8'h77, 1, 1);
    chk("flush_level", 32'(lvl0), 0);
    chk("flush_empty", 32'(emp0), 1);
    chk("flush_full",  32'(full0), 0);
    chk("flush_ovf",   32'(ovf0), 1);
    chk("flush_unf",   32'(unf0), 1);
    chk("flush_rd",    32'(rd0), 32'h2F);

    // Separate run: level 3, then reset.
    for (int i = 0; i < 3; i++) step(1, 8'(100 + i), 0);
    chk("lvl3", 32'(lvl0), 3);
    step(1, 8'h11, 1, 0, 1);
    chk("rst2_level", 32'(lvl0), 0);
    chk("rst2_empty", 32'(emp0), 1);
    chk("rst2_full",  32'(full0), 0);
    chk("rst2_ovf",   32'(ovf0), 0);
    chk("rst2_unf",   32'(unf0), 0);
    chk("rst2_rd",    32'(rd0), 0);

    // Random traffic in phases biased toward filling, draining and balance.
    for (int n = 0; n < 900; n++) begin
      case ((n / 100) % 3)
        0:       begin pp = 80; pq = 30; end
        1:       begin pp = 30; pq = 80; end
        default: begin pp = 60; pq = 60; end
      endcase
      step($urandom_range(99) < pp, 8'($urandom), $urandom_range(99) < pq,
           $urandom_range(59) == 0, $urandom_range(249) == 0);
    end
    step(0, 0, 0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
